// File: rtl/fusion_pkg.sv
// fusion_blend shared definitions:
// mode codes, unity gain, saturating clamp.
package fusion_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_MAXABS = 2'd0;
  localparam mode_t MODE_AVG    = 2'd1;
  localparam mode_t MODE_O_ONLY = 2'd2;
  localparam mode_t MODE_BYPASS = 2'd3;

  localparam int GAIN_UNITY = 4;

  function automatic logic [31:0] sat_clamp(
    input  logic signed [31:0] v,
    input  int unsigned        w,
    output logic               sat
  );
    logic signed [31:0] hi;
    hi = $signed((32'd1 << w) - 32'd1);
    sat = 1'b0;
    sat_clamp = v;
    if (v < 0) begin
      sat = 1'b1;
      sat_clamp = '0;
    end else if (v > hi) begin
      sat = 1'b1;
      sat_clamp = hi;
    end
  endfunction

endpackage

// File: rtl/fusion_blend_if.sv
// fusion_blend pixel/stat bundle.
// master drives pixels, slave is the blender.
interface fusion_blend_if #(
  parameter int W      = 8,
  parameter int LUT_W  = 3,
  parameter int GAIN_W = 4,
  parameter int CNT_W  = 24
);
  logic              isync;
  logic              ivalid;
  logic [W-1:0]      idata_g_o;
  logic [W-1:0]      idata_y_o;
  logic [W-1:0]      idata_g_t;
  logic [W-1:0]      idata_y_t;
  logic [1:0]        imode;
  logic [GAIN_W-1:0] igain;
  logic              osync;
  logic              ovalid;
  logic [W-1:0]      odata;
  logic [LUT_W-1:0]  lut_o;
  logic              ostat_valid;
  logic [CNT_W-1:0]  opix_cnt;
  logic [CNT_W-1:0]  osat_cnt;

  modport master (
    output isync, ivalid,
    output idata_g_o, idata_y_o,
    output idata_g_t, idata_y_t,
    output imode, igain,
    input  osync, ovalid, odata, lut_o,
    input  ostat_valid, opix_cnt, osat_cnt
  );

  modport slave (
    input  isync, ivalid,
    input  idata_g_o, idata_y_o,
    input  idata_g_t, idata_y_t,
    input  imode, igain,
    output osync, ovalid, odata, lut_o,
    output ostat_valid, opix_cnt, osat_cnt
  );
endinterface

// File: rtl/fusion_detail_sel.sv
// fusion_blend S2: picks or merges the two
// signed details according to the pixel mode.
module fusion_detail_sel
  import fusion_pkg::*;
#(
  parameter int W = 8
) (
  input  logic              iclk,
  input  logic              rst_i,
  input  mode_t             mode,
  input  logic signed [W:0] d_o,
  input  logic signed [W:0] d_t,
  output logic signed [W:0] det
);

  logic signed [W+1:0] sum;
  logic signed [W:0]   mx;
  logic signed [W:0]   mn;
  logic signed [W:0]   sel;
  logic                any_pos;

  assign sum     = {d_o[W], d_o} + {d_t[W], d_t};
  assign mx      = (d_o > d_t) ? d_o : d_t;
  assign mn      = (d_o < d_t) ? d_o : d_t;
  assign any_pos = ~d_o[W] | ~d_t[W];

  // detail choice; ties fall to d_t
  always_comb begin
    sel = d_o;
    unique case (1'b1)
      (mode == MODE_MAXABS): sel = any_pos ? mx : mn;
      (mode == MODE_AVG):    sel = sum[W+1:1];
      (mode == MODE_O_ONLY): sel = d_o;
      default:               sel = d_o;
    endcase
  end

  // S2 register
  always_ff @(posedge iclk or negedge rst_i) begin
    if (!rst_i) det <= '0;
    else        det <= sel;
  end

endmodule

// File: rtl/fusion_blend.sv
// fusion_blend top: detail/base fusion, 4-stage
// pipe, sync/valid alignment and frame stats.
module fusion_blend
  import fusion_pkg::*;
#(
  parameter int PIXEL_DATA_W = 8,
  parameter int LUT_W        = 3,
  parameter int GAIN_W       = 4,
  parameter int CNT_W        = 24
) (
  input logic            iclk,
  input logic            rst_i,
  fusion_blend_if.slave  bus
);

  localparam int W  = PIXEL_DATA_W;
  localparam int DW = W + 1;
  localparam int PW = DW + GAIN_W + 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FRAME = 1'b1;

  logic              isync_q;
  logic              rise_in;
  mode_t             mode_s;
  logic [GAIN_W-1:0] gain_s;
  mode_t             mode_in;
  logic [GAIN_W-1:0] gain_in;

  logic signed [DW-1:0] s1_do;
  logic signed [DW-1:0] s1_dt;
  logic [W-1:0]         s1_base;
  logic [W-1:0]         s1_y;
  mode_t                s1_mode;
  logic [GAIN_W-1:0]    s1_gain;
  logic                 s1_v;
  logic                 s1_s;

  logic signed [DW-1:0] s2_det;
  logic [W-1:0]         s2_base;
  logic [W-1:0]         s2_y;
  mode_t                s2_mode;
  logic [GAIN_W-1:0]    s2_gain;
  logic                 s2_v;
  logic                 s2_s;

  logic signed [PW-1:0] det_x;
  logic signed [PW-1:0] gain_x;
  logic signed [PW-1:0] prod;

  logic signed [PW-1:0] s3_sd;
  logic [W-1:0]         s3_base;
  logic [W-1:0]         s3_y;
  logic [LUT_W-1:0]     s3_lut;
  logic                 s3_byp;
  logic                 s3_v;
  logic                 s3_s;

  logic signed [31:0]   sum32;
  logic [31:0]          clamp_v;
  logic                 clamp_sat;

  logic [W-1:0]         s4_data;
  logic [LUT_W-1:0]     s4_lut;
  logic                 s4_v;
  logic                 s4_s;
  logic                 s4_sat;

  logic [0:0]           st;
  logic                 osync_q;
  logic [CNT_W-1:0]     pix_c;
  logic [CNT_W-1:0]     sat_c;
  logic                 stat_v;
  logic [CNT_W-1:0]     pix_r;
  logic [CNT_W-1:0]     sat_r;

  assign rise_in = bus.isync & ~isync_q;
  assign mode_in = rise_in ? bus.imode : mode_s;
  assign gain_in = rise_in ? bus.igain : gain_s;

  // shadow mode/gain latched at frame start
  always_ff @(posedge iclk or negedge rst_i) begin
    if (!rst_i) begin
      isync_q <= 1'b0;
      mode_s  <= MODE_MAXABS;
      gain_s  <= '0;
    end else begin
      isync_q <= bus.isync;
      if (rise_in) begin
        mode_s <= bus.imode;
        gain_s <= bus.igain;
      end
    end
  end

  // S1: details and averaged base
  always_ff @(posedge iclk or negedge rst_i) begin
    if (!rst_i) begin
      s1_do   <= '0;
      s1_dt   <= '0;
      s1_base <= '0;
      s1_y    <= '0;
      s1_mode <= MODE_MAXABS;
      s1_gain <= '0;
      s1_v    <= 1'b0;
      s1_s    <= 1'b0;
    end else begin
      s1_do   <= $signed({1'b0, bus.idata_y_o})
               - $signed({1'b0, bus.idata_g_o});
      s1_dt   <= $signed({1'b0, bus.idata_y_t})
               - $signed({1'b0, bus.idata_g_t});
      s1_base <= (bus.idata_g_o >> 1)
               + (bus.idata_g_t >> 1);
      s1_y    <= bus.idata_y_o;
      s1_mode <= mode_in;
      s1_gain <= gain_in;
      s1_v    <= bus.ivalid;
      s1_s    <= bus.isync;
    end
  end

  fusion_detail_sel #(
    .W (W)
  ) u_sel (
    .iclk  (iclk),
    .rst_i (rst_i),
    .mode  (s1_mode),
    .d_o   (s1_do),
    .d_t   (s1_dt),
    .det   (s2_det)
  );

  // S2 side-band alongside the detail select
  always_ff @(posedge iclk or negedge rst_i) begin
    if (!rst_i) begin
      s2_base <= '0;
      s2_y    <= '0;
      s2_mode <= MODE_MAXABS;
      s2_gain <= '0;
      s2_v    <= 1'b0;
      s2_s    <= 1'b0;
    end else begin
      s2_base <= s1_base;
      s2_y    <= s1_y;
      s2_mode <= s1_mode;
      s2_gain <= s1_gain;
      s2_v    <= s1_v;
      s2_s    <= s1_s;
    end
  end

  assign det_x  = PW'(s2_det);
  assign gain_x = $signed(PW'(s2_gain));
  assign prod   = det_x * gain_x;

  // S3: detail gain, Q.2 with floor
  always_ff @(posedge iclk or negedge rst_i) begin
    if (!rst_i) begin
      s3_sd   <= '0;
      s3_base <= '0;
      s3_y    <= '0;
      s3_lut  <= '0;
      s3_byp  <= 1'b0;
      s3_v    <= 1'b0;
      s3_s    <= 1'b0;
    end else begin
      s3_sd   <= prod >>> 2;
      s3_base <= s2_base;
      s3_y    <= s2_y;
      s3_lut  <= s2_det[LUT_W-1:0];
      s3_byp  <= (s2_mode == MODE_BYPASS);
      s3_v    <= s2_v;
      s3_s    <= s2_s;
    end
  end

  // S4 sum and clamp to pixel range
  always_comb begin
    sum32 = 32'(s3_sd) + $signed(32'(s3_base));
    clamp_v = sat_clamp(sum32, W, clamp_sat);
  end

  // S4 output register
  always_ff @(posedge iclk or negedge rst_i) begin
    if (!rst_i) begin
      s4_data <= '0;
      s4_lut  <= '0;
      s4_v    <= 1'b0;
      s4_s    <= 1'b0;
      s4_sat  <= 1'b0;
    end else begin
      s4_data <= s3_byp ? s3_y : W'(clamp_v);
      s4_lut  <= s3_lut;
      s4_v    <= s3_v;
      s4_s    <= s3_s;
      s4_sat  <= ~s3_byp & clamp_sat;
    end
  end

  // stats FSM follows the delayed sync
  always_ff @(posedge iclk or negedge rst_i) begin
    if (!rst_i) begin
      st      <= ST_IDLE;
      osync_q <= 1'b0;
      pix_c   <= '0;
      sat_c   <= '0;
      stat_v  <= 1'b0;
      pix_r   <= '0;
      sat_r   <= '0;
    end else begin
      osync_q <= s4_s;
      stat_v  <= 1'b0;
      unique case (st)
        ST_IDLE: begin
          if (s4_s & ~osync_q) begin
            st    <= ST_FRAME;
            pix_c <= CNT_W'(s4_v);
            sat_c <= CNT_W'(s4_v & s4_sat);
          end
        end
        ST_FRAME: begin
          if (!s4_s) begin
            st     <= ST_IDLE;
            pix_r  <= pix_c;
            sat_r  <= sat_c;
            stat_v <= 1'b1;
          end else begin
            if (s4_v && pix_c != '1)
              pix_c <= pix_c + 1'b1;
            if (s4_v && s4_sat && sat_c != '1)
              sat_c <= sat_c + 1'b1;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  assign bus.odata       = s4_data;
  assign bus.lut_o       = s4_lut;
  assign bus.ovalid      = s4_v;
  assign bus.osync       = s4_s;
  assign bus.ostat_valid = stat_v;
  assign bus.opix_cnt    = pix_r;
  assign bus.osat_cnt    = sat_r;

endmodule

// File: tb/tb_fusion_blend.sv
// fusion_blend bench: random frames against an
// integer reference model, queue scoreboard.
module tb_fusion_blend;

  typedef struct {
    int od;
    int lut;
    bit cl;
    int cyc;
  } exp_t;

  typedef struct {
    int pix;
    int sat;
    int cyc;
  } st_t;

  logic iclk;
  logic rst_i;
  int   cyc;
  int   nc;
  int   nf;

  exp_t q[$];
  st_t  sq[$];

  int sh_mode;
  int sh_gain;
  bit in_frame;
  int fr_pix;
  int fr_sat;
  bit has_prev;
  int pv_pix;
  int pv_sat;

  fusion_blend_if #(
    .W(8), .LUT_W(3), .GAIN_W(4), .CNT_W(24)
  ) bus ();

  fusion_blend #(
    .PIXEL_DATA_W(8), .LUT_W(3),
    .GAIN_W(4), .CNT_W(24)
  ) dut (
    .iclk  (iclk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  initial cyc = 0;
  always @(posedge iclk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input int act, input int req);
    nc++;
    if (act != req) begin
      nf++;
      $display("FAIL %s: got %0d want %0d",
               nm, act, req);
    end
  endtask

  function automatic int fdiv(input int a, input int b);
    int r;
    r = a / b;
    if ((a % b) != 0 && a < 0) r = r - 1;
    return r;
  endfunction

  function automatic void model(
    input  int m, input int g,
    input  int yo, input int go,
    input  int yt, input int gt,
    output int od, output int lut, output int sat);
    int dov, dtv, det, base, sum;
    dov  = yo - go;
    dtv  = yt - gt;
    base = go / 2 + gt / 2;
    if (m == 0) begin
      if (dov >= 0 || dtv >= 0)
        det = (dov > dtv) ? dov : dtv;
      else
        det = (dov < dtv) ? dov : dtv;
    end else if (m == 1) begin
      det = fdiv(dov + dtv, 2);
    end else begin
      det = dov;
    end
    sum = base + fdiv(det * g, 4);
    lut = det & 7;
    sat = 0;
    if (m == 3) od = yo;
    else if (sum < 0) begin od = 0; sat = 1; end
    else if (sum > 255) begin od = 255; sat = 1; end
    else od = sum;
  endfunction

  task automatic px(input bit v,
                    input int yo, input int go,
                    input int yt, input int gt,
                    input bit dir = 1'b0,
                    input int e_od = 0,
                    input int e_lut = 0,
                    input int e_sat = 0);
    int od, lu, s;
    exp_t e;
    @(posedge iclk); #1;
    bus.ivalid    = v;
    bus.idata_y_o = yo[7:0];
    bus.idata_g_o = go[7:0];
    bus.idata_y_t = yt[7:0];
    bus.idata_g_t = gt[7:0];
    if (dir) begin
      od = e_od; lu = e_lut; s = e_sat;
    end else begin
      model(sh_mode, sh_gain, yo, go, yt, gt,
            od, lu, s);
    end
    if (v) begin
      e.od  = od;
      e.lut = lu;
      e.cl  = (sh_mode != 3);
      e.cyc = cyc + 4;
      q.push_back(e);
      if (in_frame) begin
        fr_pix++;
        fr_sat += s;
      end
    end
  endtask

  task automatic rpx();
    px($urandom_range(0, 3) != 0,
       $urandom_range(0, 255), $urandom_range(0, 255),
       $urandom_range(0, 255), $urandom_range(0, 255));
  endtask

  task automatic frame_start(input int m, input int g);
    @(posedge iclk); #1;
    bus.isync  = 1'b1;
    bus.ivalid = 1'b0;
    bus.imode  = m[1:0];
    bus.igain  = g[3:0];
    sh_mode  = m;
    sh_gain  = g;
    in_frame = 1'b1;
    fr_pix   = 0;
    fr_sat   = 0;
  endtask

  task automatic frame_end();
    st_t s;
    @(posedge iclk); #1;
    bus.isync  = 1'b0;
    bus.ivalid = 1'b0;
    if (has_prev) begin
      chk("held_pix", int'(bus.opix_cnt), pv_pix);
      chk("held_sat", int'(bus.osat_cnt), pv_sat);
    end
    s.pix = fr_pix;
    s.sat = fr_sat;
    s.cyc = cyc + 5;
    sq.push_back(s);
    pv_pix   = fr_pix;
    pv_sat   = fr_sat;
    has_prev = 1'b1;
    in_frame = 1'b0;
    repeat (8) px(0, 0, 0, 0, 0);
  endtask

  task automatic rnd_frame(input int m, input int g,
                           input int n);
    frame_start(m, g);
    repeat (n) rpx();
    frame_end();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_odata"}, int'(bus.odata), 0);
    chk({tag, "_ovalid"}, int'(bus.ovalid), 0);
    chk({tag, "_osync"}, int'(bus.osync), 0);
    chk({tag, "_lut"}, int'(bus.lut_o), 0);
    chk({tag, "_stv"}, int'(bus.ostat_valid), 0);
    chk({tag, "_pix"}, int'(bus.opix_cnt), 0);
    chk({tag, "_sat"}, int'(bus.osat_cnt), 0);
  endtask

  // monitor: pops the scoreboard on every output
  initial begin
    exp_t e;
    st_t  s;
    forever begin
      @(posedge iclk); #1;
      if (rst_i) begin
        if (bus.ovalid) begin
          if (q.size() == 0) begin
            chk("spurious_ovalid", 1, 0);
          end else begin
            e = q.pop_front();
            chk("latency", cyc, e.cyc);
            chk("odata", int'(bus.odata), e.od);
            if (e.cl)
              chk("lut_o", int'(bus.lut_o), e.lut);
          end
        end
        if (bus.ostat_valid) begin
          if (sq.size() == 0) begin
            chk("spurious_stat", 1, 0);
          end else begin
            s = sq.pop_front();
            chk("stat_cyc", cyc, s.cyc);
            chk("opix_cnt", int'(bus.opix_cnt), s.pix);
            chk("osat_cnt", int'(bus.osat_cnt), s.sat);
          end
        end
      end
    end
  end

  initial begin
    nc = 0;
    nf = 0;
    sh_mode  = 0;
    sh_gain  = 0;
    in_frame = 1'b0;
    has_prev = 1'b0;
    pv_pix   = 0;
    pv_sat   = 0;
    rst_i         = 1'b0;
    bus.isync     = 1'b0;
    bus.ivalid    = 1'b0;
    bus.idata_y_o = '0;
    bus.idata_g_o = '0;
    bus.idata_y_t = '0;
    bus.idata_g_t = '0;
    bus.imode     = '0;
    bus.igain     = '0;
    repeat (3) @(posedge iclk);
    @(negedge iclk);
    chk_zero("rst");
    rst_i = 1'b1;

    // shadow at reset: MAXABS, gain 0 -> base only
    px(1, 200, 100, 50, 80, 1'b1, 90, 4, 0);
    repeat (4) rpx();

    // frame A: directed MAXABS, then mode change
    frame_start(0, 4);
    px(1, 200, 100, 50, 80, 1'b1, 190, 4, 0);
    px(1, 60, 70, 40, 80, 1'b1, 35, 0, 0);
    repeat (20) rpx();
    bus.imode = 2'd3;
    repeat (20) rpx();
    frame_end();

    // frame B: bypass applies from its start
    rnd_frame(3, 4, 30);

    // frame C: saturation at gain 8
    frame_start(0, 8);
    px(1, 255, 0, 255, 0, 1'b1, 255, 7, 1);
    px(1, 0, 200, 0, 200, 1'b1, 0, 0, 1);
    repeat (15) rpx();
    frame_end();

    // stats frame: 100 valid, 3 clamped
    frame_start(0, 4);
    for (int i = 0; i < 100; i++) begin
      int a, b;
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      if (i % 7 == 3) px(0, a, b, b, a);
      if (i == 10 || i == 50 || i == 90)
        px(1, 255, 0, 255, 255, 1'b1, 255, 7, 1);
      else
        px(1, a, a, b, b);
    end
    frame_end();

    // one-cycle frame still pulses
    frame_start(1, 4);
    frame_end();

    rnd_frame(1, 6, 25);

    // reset mid-frame
    frame_start(2, 4);
    repeat (10) rpx();
    @(negedge iclk);
    rst_i = 1'b0;
    #1;
    chk_zero("midrst");
    q.delete();
    bus.isync  = 1'b0;
    bus.ivalid = 1'b0;
    sh_mode  = 0;
    sh_gain  = 0;
    in_frame = 1'b0;
    has_prev = 1'b0;
    @(negedge iclk);
    @(negedge iclk);
    rst_i = 1'b1;
    repeat (3) rpx();

    rnd_frame(1, 6, 40);
    for (int k = 0; k < 4; k++)
      rnd_frame($urandom_range(0, 3),
                $urandom_range(0, 15), 30);

    for (int i = 0; i < 40; i++) begin
      if (q.size() == 0 && sq.size() == 0) break;
      @(posedge iclk);
    end
    #2;
    chk("drain_pix_q", q.size(), 0);
    chk("drain_stat_q", sq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nc, nf);
    $finish;
  end

endmodule

// File: doc/fusion_blend.md
# fusion_blend

Parametrised successor to the two-source detail/base fusion stage. It combines an "o" and a "t" source, each given as base (g) and original (y) planes. Detail is d = y − g. The block selects or merges the two details, applies a programmable detail gain, adds the averaged base and saturates the result. It sits after the two base-layer filters and ahead of the display/LUT path, and adds pipeline-aligned sync plus per-frame statistics.

## Interface
- PIXEL_DATA_W, 8, pixel width W
- LUT_W, 3, LUT index width (≤ W)
- GAIN_W, 4, detail gain width, unsigned Q(GAIN_W−2).2; value 4 = unity
- CNT_W, 24, statistics counter width
- iclk  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low
- isync  in  1  frame sync, level: high for the frame; rise = start, fall = end
- ivalid  in  1  pixel qualifier
- idata_g_o, idata_y_o, idata_g_t, idata_y_t  in  W  base/original for sources o and t, unsigned
- imode  in  2  0 MAXABS, 1 AVG, 2 O_ONLY, 3 BYPASS
- igain  in  GAIN_W  detail gain
- osync  out  1  isync delayed by pipeline latency
- ovalid  out  1  ivalid delayed by pipeline latency
- odata  out  W  fused pixel
- lut_o  out  LUT_W  low LUT_W bits of the selected (pre-gain) detail, aligned with odata
- ostat_valid  out  1  one-cycle pulse at frame end
- opix_cnt, osat_cnt  out  CNT_W  valid pixels and clamped pixels of last frame; held until next pulse

## Operation
- Shadow regs mode_s/gain_s load imode/igain on the isync rising edge. They are constant for the frame. Each pixel carries its mode/gain down the pipe, so in-flight pixels are never affected by a shadow update.
- S1: d_o = y_o − g_o, d_t = y_t − g_t, both (W+1)-bit signed. base = (g_o>>1) + (g_t>>1), W bits, cannot overflow.
- S2, detail select:
  - MAXABS: if either detail is ≥ 0, take the signed max; if both are < 0, take the signed min. Ties take d_t.
  - AVG: (d_o + d_t) >>> 1, floor.
  - O_ONLY: d_o.
  - BYPASS: detail is ignored and the output is y_o.
- S3: sd = (d × gain_s) >>> 2, full-width signed, floor.
- S4: sum = base + sd. Clamp to [0, 2^W−1]. sat = 1 when clamping occurred. BYPASS never sets sat.
- Stats FSM runs on the S4 side, driven by osync edges:
  - IDLE → FRAME on osync rise: clear both counters.
  - In FRAME, count ovalid pixels and ovalid&sat pixels. Counters stick at all-ones.
  - FRAME → IDLE on osync fall: load opix_cnt/osat_cnt and pulse ostat_valid.
- Pixels with ivalid while isync is low are processed normally but not counted.
- ivalid low: the pipe still advances. odata/lut_o hold don't-care data; benches check only when ovalid = 1.

## Timing
- Latency is 4 cycles from input to odata/lut_o/ovalid/osync. Throughput is 1 pixel/clock, with no backpressure.
- ostat_valid asserts 1 cycle after the cycle in which osync is first seen low.
- Reset, asynchronous and active-low, clears all outputs, pipe, shadow regs and counters to 0, and forces the FSM to IDLE.
  - Reset mid-frame produces no stat pulse.
  - The frame is not counted unless an osync rise is seen after reset release.
- Shadow regs are 0 after reset (mode MAXABS, gain 0) until the first isync rise.
- A 1-cycle isync high still produces a full FRAME/IDLE cycle with a pulse.

## Structure
- Package fusion_pkg holds the mode encodings, the unity-gain constant (4) and a saturating-clamp function.
- One sub-module, fusion_detail_sel: registered S2 select, parametrised by W.
- Top holds S1, S3, S4, the sync/valid delay line and the stats FSM.

## Test plan
W=8, gain=4 unless stated.
- MAXABS, opposite signs: y_o=200, g_o=100, y_t=50, g_t=80 → d=+100, base=90, odata=190, lut_o=4, ovalid 4 cycles after ivalid.
- MAXABS, both negative: y_o=60, g_o=70, y_t=40, g_t=80 → d=−40, base=75, odata=35, lut_o=0.
- Saturation with gain=8: y_o=y_t=255, g_o=g_t=0 → 255, sat. Then y=0, g=200 (both sources) → sum −200, clamps to 0, sat.
- Mode/gain applied per frame: change imode from 0 to 3 mid-frame → the rest of the frame stays MAXABS; the next frame outputs y_o exactly.
- Stats: frame of 100 valid pixels including 3 clamping → ostat_valid pulse, opix_cnt=100, osat_cnt=3, held through the next frame.
- Reset mid-frame: rst_i low for 2 cycles → all outputs 0 immediately, no ostat_valid; the next full frame counts correctly.
